// File: rtl/mux_scan_n_pkg.sv
// Shared constants and helpers for the registered N-channel scan multiplexer.
package mux_scan_n_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Counter width that stays at least one bit even when the count range is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_n_if.sv
// Source/consumer bundle of the scan multiplexer; master drives samples, slave is the mux.
interface mux_scan_n_if #(
  parameter int N_CH = 4,
  parameter int W    = 8
);
  localparam int SELW = $clog2(N_CH);

  logic              mode;
  logic [SELW-1:0]   sel;
  logic [N_CH*W-1:0] din;
  logic              en;
  logic              out_ready;
  logic              out_valid;
  logic [W-1:0]      dout;
  logic [SELW-1:0]   ch_out;
  logic              frame_start;
  logic              sel_err;

  modport master (
    output mode, sel, din, en, out_ready,
    input  out_valid, dout, ch_out, frame_start, sel_err
  );

  modport slave (
    input  mode, sel, din, en, out_ready,
    output out_valid, dout, ch_out, frame_start, sel_err
  );

endinterface

// File: rtl/mux_scan_n_scan_ctr.sv
// Channel-rotation pointer with per-channel dwell count; counts accepted loads, not cycles.
module mux_scan_n_scan_ctr
  import mux_scan_n_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DWELL = 1,
  parameter int SELW  = $clog2(N_CH),
  parameter int DCW   = cnt_w(DWELL)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            adv,
  output logic [SELW-1:0] cur_ptr,
  output logic            first
);

  logic [SELW-1:0] ptr_q, ptr_d;
  logic [DCW-1:0]  dcnt_q, dcnt_d, dcnt_c;

  // A clear acts on the current cycle so a load in that cycle already sees channel 0.
  always_comb begin
    cur_ptr = clr ? '0 : ptr_q;
    dcnt_c  = clr ? '0 : dcnt_q;
    first   = (cur_ptr == '0) && (dcnt_c == '0);
    ptr_d   = cur_ptr;
    dcnt_d  = dcnt_c;
    if (adv) begin
      if (dcnt_c == DCW'(DWELL - 1)) begin
        dcnt_d = '0;
        ptr_d  = (cur_ptr == SELW'(N_CH - 1)) ? '0 : cur_ptr + 1'b1;
      end else begin
        dcnt_d = dcnt_c + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      dcnt_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      dcnt_q <= dcnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N:1 multiplexer with direct-select and auto-scan modes and a valid/ready output.
module mux_scan_n
  import mux_scan_n_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int DWELL = 1
) (
  input logic        clk,
  input logic        rst,
  mux_scan_n_if.slave bus
);

  localparam int SELW = $clog2(N_CH);

  logic            mode_q;
  logic            mode_chg;
  logic            scan;
  logic            load;
  logic            first;
  logic [SELW-1:0] cur_ptr;
  logic [SELW-1:0] ch;
  logic [W-1:0]    pick;
  logic            err;

  logic            vld_p1;
  logic [W-1:0]    dout_p1;
  logic [SELW-1:0] ch_p1;
  logic            fs_p1;
  logic            err_p1;

  assign mode_chg = (bus.mode != mode_q);
  assign scan     = (bus.mode == MODE_SCAN);
  assign load     = bus.en && (!vld_p1 || bus.out_ready);

  mux_scan_n_scan_ctr #(
    .N_CH  (N_CH),
    .DWELL (DWELL),
    .SELW  (SELW)
  ) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr     (mode_chg),
    .adv     (load && scan),
    .cur_ptr (cur_ptr),
    .first   (first)
  );

  // Stage p0: channel select; an out-of-range index matches no channel and yields zero.
  always_comb begin
    ch   = scan ? cur_ptr : bus.sel;
    err  = !scan && (32'(bus.sel) >= N_CH);
    pick = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch == SELW'(k)) pick = bus.din[k*W +: W];
    end
  end

  // Stage p1: output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_DIRECT;
      vld_p1  <= 1'b0;
      dout_p1 <= '0;
      ch_p1   <= '0;
      fs_p1   <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      mode_q <= bus.mode;
      if (load) begin
        vld_p1  <= 1'b1;
        dout_p1 <= pick;
        ch_p1   <= ch;
        fs_p1   <= scan && first;
        err_p1  <= err;
      end else if (bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = vld_p1;
  assign bus.dout        = dout_p1;
  assign bus.ch_out      = ch_p1;
  assign bus.frame_start = fs_p1;
  assign bus.sel_err     = err_p1;

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: three instances (4ch/dwell1, 3ch/dwell2, 3ch/dwell1) share stimulus.
module tb_mux_scan_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode, en, rdy;
  logic [1:0]  sel;
  logic [31:0] din;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux_scan_n_if #(.N_CH(4), .W(8)) ia ();
  mux_scan_n_if #(.N_CH(3), .W(8)) ib ();
  mux_scan_n_if #(.N_CH(3), .W(8)) ic ();

  assign ia.mode = mode;  assign ia.sel = sel;  assign ia.din = din;
  assign ia.en   = en;    assign ia.out_ready = rdy;
  assign ib.mode = mode;  assign ib.sel = sel;  assign ib.din = din[23:0];
  assign ib.en   = en;    assign ib.out_ready = rdy;
  assign ic.mode = mode;  assign ic.sel = sel;  assign ic.din = din[23:0];
  assign ic.en   = en;    assign ic.out_ready = rdy;

  mux_scan_n #(.N_CH(4), .W(8), .DWELL(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  mux_scan_n #(.N_CH(3), .W(8), .DWELL(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  mux_scan_n #(.N_CH(3), .W(8), .DWELL(1)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    mode = 1'b0;
    en   = 1'b0;
    rdy  = 1'b1;
    step();
    rst  = 1'b0;
  endtask

  // Expected tables for the 3-channel, dwell-2 run with an en gap.
  logic        b_en [10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
  logic        b_vld[10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
  logic [1:0]  b_ch [10] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 0};
  logic        b_fs [10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  logic [7:0]  b_dat[10] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
                             8'h22, 8'h33, 8'h33, 8'h11};

  initial begin
    sel = 2'd0;
    din = 32'h4433_2211;
    do_reset();
    step();
    chk("rst_valid", ia.out_valid, 0);
    chk("rst_dout", ia.dout, 0);
    chk("rst_ch", ia.ch_out, 0);
    chk("rst_fs", ia.frame_start, 0);
    chk("rst_err", ia.sel_err, 0);

    // Direct select of channel 2
    sel = 2'd2; en = 1'b1;
    step();
    chk("dir_dout", ia.dout, 8'h33);
    chk("dir_ch", ia.ch_out, 2);
    chk("dir_valid", ia.out_valid, 1);
    chk("dir_fs", ia.frame_start, 0);
    chk("dir_err", ia.sel_err, 0);

    // Scan, dwell 1: 4-channel and 3-channel wrap side by side
    do_reset();
    mode = 1'b1; en = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("scanA_ch", ia.ch_out, 32'(i % 4));
      chk("scanA_fs", ia.frame_start, 32'(i % 4 == 0));
      chk("scanA_dout", ia.dout, 32'(din[8*(i%4) +: 8]));
      chk("scanA_valid", ia.out_valid, 1);
      chk("scanC_ch", ic.ch_out, 32'(i % 3));
      chk("scanC_fs", ic.frame_start, 32'(i % 3 == 0));
    end

    // Scan, dwell 2, with en dropped for three cycles
    do_reset();
    mode = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      en = b_en[i];
      step();
      chk("scanB_valid", ib.out_valid, 32'(b_vld[i]));
      chk("scanB_ch", ib.ch_out, 32'(b_ch[i]));
      chk("scanB_dout", ib.dout, 32'(b_dat[i]));
      chk("scanB_fs", ib.frame_start, 32'(b_fs[i]));
    end

    // Backpressure: hold 8'h22 while inputs churn
    do_reset();
    mode = 1'b0; sel = 2'd1; din = 32'h4433_2211; en = 1'b1; rdy = 1'b1;
    step();
    chk("bp_load", ia.dout, 8'h22);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i * 3 + 2);
      din = 32'hDEAD_0000 + 32'(i * 32'h0101_0101);
      step();
      chk("bp_hold_dout", ia.dout, 8'h22);
      chk("bp_hold_ch", ia.ch_out, 1);
      chk("bp_hold_valid", ia.out_valid, 1);
    end
    rdy = 1'b1; sel = 2'd3; din = 32'hA1B2_C3D4;
    step();
    chk("bp_next_dout", ia.dout, 8'hA1);
    chk("bp_next_ch", ia.ch_out, 3);
    chk("bp_next_valid", ia.out_valid, 1);
    en = 1'b0;
    step();
    chk("bp_drain_valid", ia.out_valid, 0);

    // Out-of-range select on the 3-channel instance
    do_reset();
    mode = 1'b0; sel = 2'd3; din = 32'h4433_2211; en = 1'b1; rdy = 1'b1;
    step();
    chk("oor_dout", ic.dout, 0);
    chk("oor_err", ic.sel_err, 1);
    chk("oor_ch", ic.ch_out, 3);
    chk("oor_valid", ic.out_valid, 1);
    sel = 2'd1;
    step();
    chk("oor_clr_dout", ic.dout, 8'h22);
    chk("oor_clr_err", ic.sel_err, 0);
    chk("oor_clr_ch", ic.ch_out, 1);

    // Reset in the middle of a scan with ptr at 2
    do_reset();
    mode = 1'b1; en = 1'b1; rdy = 1'b1;
    step();
    step();
    chk("rms_pre_ch", ic.ch_out, 1);
    rst = 1'b1;
    step();
    chk("rms_valid", ic.out_valid, 0);
    chk("rms_dout", ic.dout, 0);
    chk("rms_ch", ic.ch_out, 0);
    chk("rms_fs", ic.frame_start, 0);
    rst = 1'b0;
    step();
    chk("rms_first_ch", ic.ch_out, 0);
    chk("rms_first_fs", ic.frame_start, 1);
    chk("rms_first_dout", ic.dout, 8'h11);
    chk("rms_first_valid", ic.out_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
